ps2_receiver: RTL and testbench



---
 rtl/ps2_receiver_pkg.sv | 30 +++
 rtl/ps2_line_filter.sv | 59 +++++
 rtl/ps2_receiver.sv | 132 +++++++++++++
 tb/tb_ps2_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_receiver_pkg
//  Purpose  : Shared PS/2 frame constants, receiver FSM states and frame check
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_receiver_pkg;

    // Frame layout: start, 8 data bits LSB first, odd parity, stop
    localparam int   PS2_FRAME_BITS = 11;
    localparam int   PS2_DATA_BITS  = PS2_FRAME_BITS - 3;
    localparam logic PS2_START_BIT  = 1'b0;
    localparam logic PS2_STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // A frame is accepted when the stop bit is high and data+parity has odd weight
    function automatic logic ps2_frame_ok(input logic [7:0] data,
                                          input logic       parity,
                                          input logic       stop);
        return (stop == PS2_STOP_BIT) && ((^data ^ parity) == 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_filter
//  Purpose  : 2-FF synchroniser plus run-length glitch filter for one PS/2
//             line; emits a single-cycle pulse when the filtered level falls.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic fall_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic       prev_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Level only flips after FILTER_LEN consecutive differing samples
    always_comb begin
        level_d = level_q;
        cnt_d   = 8'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == 8'(FILTER_LEN - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Synchroniser, filter state and previous level (line idles high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // High in the first cycle the filtered level reads 0 after having been 1
    assign fall_o = prev_q & ~level_q;

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_receiver
//  Purpose  : PS/2 device-to-host frame deserialiser with parity/stop check
//             and in-frame stall timeout. Receive only.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       scan_code_ready,
    output logic [7:0] scan_code,
    output logic       frame_error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic             fall;
    logic             data_s1_q;
    logic             data_s2_q;
    ps2_state_e       state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [TMO_W-1:0] tmo_q;
    logic             ready_q;
    logic             error_q;
    logic [7:0]       code_q;
    logic             tmo_hit;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .line_i (ps2_clk),
        .fall_o (fall)
    );

    // Data line only needs synchronising; it is sampled on filtered clock falls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    // A fall event in the same cycle beats the timeout
    assign tmo_hit = (state_q != ST_IDLE) && !fall &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Frame FSM with stall timer and registered result pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= 8'd0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;

            if (state_q == ST_IDLE || fall || tmo_hit) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // A high bit here is a stray edge, not a start bit
                    if (fall && data_s2_q == PS2_START_BIT) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        shift_q   <= {data_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                            state_q <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fall) begin
                        parity_q <= data_s2_q;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall) begin
                        if (ps2_frame_ok(shift_q, parity_q, data_s2_q)) begin
                            code_q  <= shift_q;
                            ready_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (tmo_hit) begin
                state_q <= ST_IDLE;
                error_q <= 1'b1;
            end
        end
    end

    assign scan_code_ready = ready_q;
    assign scan_code       = code_q;
    assign frame_error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_receiver
//  Purpose  : Self-checking bench for ps2_receiver using a frame-level model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int HALF = 100;   // PS/2 half period in system clocks

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       scan_code_ready;
    logic [7:0] scan_code;
    logic       frame_error;

    ps2_receiver #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .scan_code_ready (scan_code_ready),
        .scan_code       (scan_code),
        .frame_error     (frame_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed activity
    int         rdy_cycles = 0;
    int         err_cycles = 0;
    int         both_cycles = 0;
    int unsigned err_cyc = 0;
    logic [7:0] got_codes[$];

    always @(negedge clk) begin
        if (scan_code_ready) begin
            rdy_cycles = rdy_cycles + 1;
            got_codes.push_back(scan_code);
        end
        if (frame_error) begin
            err_cycles = err_cycles + 1;
            err_cyc    = cyc;
        end
        if (scan_code_ready && frame_error) both_cycles = both_cycles + 1;
    end

    // Reference model state
    int         exp_rdy = 0;
    int         exp_err = 0;
    logic [7:0] exp_code = 8'h00;
    logic [7:0] exp_codes[$];

    int tests = 0;
    int fails = 0;
    int unsigned last_fall = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the first n bits of a frame (bit 0 first); optional short low
    // glitches on ps2_clk during the high phase of the data bits
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cycles(HALF / 2);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
            if (glitch && i >= 1 && i <= 8) begin
                wait_cycles(20);
                ps2_clk = 1'b0;
                wait_cycles(2);
                ps2_clk = 1'b1;
                wait_cycles(HALF / 2 - 22);
            end else begin
                wait_cycles(HALF / 2);
            end
        end
        ps2_data = 1'b1;
    endtask

    // Send one whole frame and predict its outcome from the frame rules
    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp, input bit glitch);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        send_bits({stp, par, d, 1'b0}, 11, glitch);
        if (stp && ((ones + int'(par)) % 2 == 1)) begin
            exp_rdy++;
            exp_code = d;
            exp_codes.push_back(d);
        end else begin
            exp_err++;
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 0);
    endfunction

    task automatic check_all(input string tag);
        wait_cycles(40);
        chk({tag, "_ready_cycles"}, rdy_cycles, exp_rdy);
        chk({tag, "_error_cycles"}, err_cycles, exp_err);
        chk({tag, "_scan_code"}, int'(scan_code), int'(exp_code));
        chk({tag, "_ready_and_error"}, both_cycles, 0);
        chk({tag, "_code_count"}, got_codes.size(), exp_codes.size());
        while (got_codes.size() > 0 && exp_codes.size() > 0)
            chk({tag, "_code_value"}, int'(got_codes.pop_front()),
                int'(exp_codes.pop_front()));
        got_codes.delete();
        exp_codes.delete();
    endtask

    initial begin
        int e0;
        logic [7:0] d;
        logic par;
        logic stp;

        // Reset state
        wait_cycles(5);
        chk("reset_ready", int'(scan_code_ready), 0);
        chk("reset_code", int'(scan_code), 0);
        chk("reset_error", int'(frame_error), 0);
        reset = 1'b1;
        wait_cycles(20);

        // Single valid frame
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check_all("single_1C");

        // Back-to-back frames
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check_all("b2b_F0_1C");

        // Wrong parity
        send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
        check_all("bad_parity_E0");

        // Bad stop then valid frame
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_all("bad_stop_1C");
        send_frame(8'h12, odd_par(8'h12), 1'b1, 1'b0);
        check_all("after_bad_stop_12");

        // Clock glitches must be filtered out
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        check_all("glitch_1C");

        // Stray high bit in idle is ignored, next frame still framed correctly
        send_bits(11'h7FF, 1, 1'b0);
        send_frame(8'h3A, odd_par(8'h3A), 1'b1, 1'b0);
        check_all("spurious_edge");

        // Stalled frame: 5 bits then silence
        e0 = err_cycles;
        send_bits({1'b1, odd_par(8'h77), 8'h77, 1'b0}, 5, 1'b0);
        for (int k = 0; k < TMO + 200 && err_cycles == e0; k++) wait_cycles(1);
        exp_err++;
        chk("timeout_error_seen", err_cycles, e0 + 1);
        chk("timeout_window",
            int'((err_cyc - last_fall) >= TMO + FILT && (err_cyc - last_fall) <= TMO + FILT + 6), 1);
        check_all("timeout");
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check_all("after_timeout");

        // Reset mid-frame
        send_bits({1'b1, odd_par(8'h5A), 8'h5A, 1'b0}, 4, 1'b0);
        reset = 1'b0;
        wait_cycles(5);
        chk("midreset_ready", int'(scan_code_ready), 0);
        chk("midreset_code", int'(scan_code), 0);
        chk("midreset_error", int'(frame_error), 0);
        exp_code = 8'h00;
        wait_cycles(10);
        reset = 1'b1;
        wait_cycles(30);
        check_all("after_reset");
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
        check_all("post_reset_5A");

        // Randomised frames
        for (int n = 0; n < 8; n++) begin
            d   = 8'($urandom_range(0, 255));
            par = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
            stp = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            send_frame(d, par, stp, 1'($urandom_range(0, 1)));
            check_all("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
